// File: rtl/outlier_compactor_pkg.sv
// outlier_compactor_pkg
//   Shared definitions for the outlier compactor slice: the FSM state
//   encoding and the lane-count / index-width derivation helpers.
package outlier_compactor_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Total lane count of one registered vector.
  function automatic int lane_count(input int size, input int par);
    return size * par;
  endfunction

  // Index width for n lanes, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/outlier_compactor_if.sv
// outlier_compactor_if
//   Bundles the three handshake streams of the outlier compactor.
//   Ports (slave = compactor view):
//     data_in / ind_table / data_in_valid / data_in_ready    input vector
//     dense_out / dense_count / dense_out_valid / _ready     dense stream
//     outlier_data / _idx / _last / _valid / _ready          outlier stream
//   master is the environment view (drives inputs and readies).
interface outlier_compactor_if
  import outlier_compactor_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int N         = 4,
  parameter int IDX_WIDTH = idx_width(N)
);

  logic [N-1:0][IN_WIDTH-1:0] data_in;
  logic [N-1:0]               ind_table;
  logic                       data_in_valid;
  logic                       data_in_ready;

  logic [N-1:0][IN_WIDTH-1:0] dense_out;
  logic [IDX_WIDTH:0]         dense_count;
  logic                       dense_out_valid;
  logic                       dense_out_ready;

  logic [IN_WIDTH-1:0]        outlier_data;
  logic [IDX_WIDTH-1:0]       outlier_idx;
  logic                       outlier_last;
  logic                       outlier_valid;
  logic                       outlier_ready;

  modport master (
    output data_in, ind_table, data_in_valid, dense_out_ready, outlier_ready,
    input  data_in_ready, dense_out, dense_count, dense_out_valid,
           outlier_data, outlier_idx, outlier_last, outlier_valid
  );

  modport slave (
    input  data_in, ind_table, data_in_valid, dense_out_ready, outlier_ready,
    output data_in_ready, dense_out, dense_count, dense_out_valid,
           outlier_data, outlier_idx, outlier_last, outlier_valid
  );

endinterface

// File: rtl/outlier_compactor_lsb_priority_encoder.sv
// lsb_priority_encoder
//   Finds the lowest set bit of a mask.
//   Ports:
//     mask     in   N          bits to search
//     idx      out  IDX_WIDTH  index of lowest set bit (0 when mask is 0)
//     any_set  out  1          mask has at least one bit set
//     onehot   out  N          one-hot of the lowest set bit (0 when mask is 0)
module lsb_priority_encoder
  import outlier_compactor_pkg::*;
#(
  parameter int N         = 4,
  parameter int IDX_WIDTH = idx_width(N)
) (
  input  logic [N-1:0]         mask,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_set,
  output logic [N-1:0]         onehot
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_WIDTH'(i);
    end
  end

  assign any_set = |mask;

  // Two's-complement trick: mask & -mask isolates the lowest set bit.
  assign onehot = mask & (~mask + N'(1));

endmodule

// File: rtl/outlier_compactor.sv
// outlier_compactor
//   Registers one vector plus its outlier flag table, then emits a dense
//   copy with outlier lanes zeroed and, independently, one (index, value)
//   beat per outlier in ascending lane order. A new vector is accepted only
//   after both streams have finished.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   outlier_compactor_if.slave (input, dense and outlier streams)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a vector, data_in_ready high
//   EMIT  | vector held; dense beat and outlier beats pending
module outlier_compactor
  import outlier_compactor_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1
) (
  input  logic               clk,
  input  logic               rst,
  outlier_compactor_if.slave bus
);

  localparam int N         = lane_count(IN_SIZE, IN_PARALLELISM);
  localparam int IDX_WIDTH = idx_width(N);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] EMIT = ST_EMIT;

  logic [0:0]                 state_q;
  logic [N-1:0][IN_WIDTH-1:0] data_q;
  logic [N-1:0][IN_WIDTH-1:0] dense_q;
  logic [N-1:0][IN_WIDTH-1:0] masked;
  logic [N-1:0]               mask_q;
  logic [N-1:0]               mask_next;
  logic [N-1:0]               low_onehot;
  logic [IDX_WIDTH:0]         count_q;
  logic                       dense_done_q;
  logic [IDX_WIDTH-1:0]       low_idx;
  logic                       any_set;
  logic                       dense_hs;
  logic                       outlier_hs;
  logic                       dense_fin;

  function automatic logic [IDX_WIDTH:0] popcount(input logic [N-1:0] v);
    logic [IDX_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{IDX_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  lsb_priority_encoder #(
    .N         (N),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_enc (
    .mask    (mask_q),
    .idx     (low_idx),
    .any_set (any_set),
    .onehot  (low_onehot)
  );

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = bus.ind_table[i] ? '0 : bus.data_in[i];
    end
  end

  // Ready is forced low while reset is held so nothing is offered a
  // handshake that the cleared registers could not honour.
  assign bus.data_in_ready   = (state_q == IDLE) && !rst;

  // Dense payload is latched at accept, so it stays fixed for the vector.
  assign bus.dense_out_valid = (state_q == EMIT) && !dense_done_q;
  assign bus.dense_out       = dense_q;
  assign bus.dense_count     = count_q;

  // mask_q is only non-zero in EMIT, so it alone qualifies the stream.
  assign bus.outlier_valid   = any_set;
  assign bus.outlier_idx     = low_idx;
  assign bus.outlier_data    = data_q[low_idx];
  assign bus.outlier_last    = (popcount(mask_q) == (IDX_WIDTH + 1)'(1));

  assign dense_hs   = bus.dense_out_valid && bus.dense_out_ready;
  assign outlier_hs = bus.outlier_valid && bus.outlier_ready;
  assign mask_next  = outlier_hs ? (mask_q & ~low_onehot) : mask_q;
  assign dense_fin  = dense_done_q || dense_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      dense_q      <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      dense_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.data_in_valid) begin
            data_q       <= bus.data_in;
            dense_q      <= masked;
            mask_q       <= bus.ind_table;
            count_q      <= popcount(bus.ind_table);
            dense_done_q <= 1'b0;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          mask_q <= mask_next;
          if (dense_hs) dense_done_q <= 1'b1;
          // Both streams may finish on the same edge; exit right then.
          if (dense_fin && (mask_next == '0)) begin
            dense_done_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outlier_compactor.sv
// tb_outlier_compactor
//   Directed bench for outlier_compactor (4 lanes x 16 bit): a vector table
//   with hand-computed expectations, then hand-written sequences for
//   outlier stalls, dense back-pressure, mid-vector reset and back-to-back
//   vectors under random readies.
module tb_outlier_compactor;
  import outlier_compactor_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  outlier_compactor_if #(.IN_WIDTH(W), .N(N), .IDX_WIDTH(IW)) bus ();

  outlier_compactor #(
    .IN_WIDTH       (W),
    .IN_SIZE        (4),
    .IN_PARALLELISM (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  ind;
    logic [63:0] data;
    logic [63:0] dense;
    logic [2:0]  cnt;
    int          n_out;
    logic [7:0]  bidx;
    logic [63:0] bval;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ind, input logic [63:0] d);
    int t;
    t = 0;
    while (!bus.data_in_ready && t < 50) begin
      step();
      t++;
    end
    if (!bus.data_in_ready) chk("send_wait_ready", 64'(bus.data_in_ready), 64'(1));
    bus.ind_table     = ind;
    bus.data_in       = d;
    bus.data_in_valid = 1'b1;
    step();
    bus.data_in_valid = 1'b0;
  endtask

  function automatic logic [63:0] zero_lanes(input logic [63:0] d, input logic [3:0] m);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 4; i++) if (m[i]) r[16*i +: 16] = 16'h0;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.data_in         = '0;
    bus.ind_table       = '0;
    bus.data_in_valid   = 1'b0;
    bus.dense_out_ready = 1'b1;
    bus.outlier_ready   = 1'b1;

    // ---------------- reset state ----------------
    #2;
    chk("rst data_in_ready",   64'(bus.data_in_ready),   64'(0));
    chk("rst dense_out_valid", 64'(bus.dense_out_valid), 64'(0));
    chk("rst outlier_valid",   64'(bus.outlier_valid),   64'(0));
    chk("rst outlier_last",    64'(bus.outlier_last),    64'(0));
    chk("rst dense_out",       64'(bus.dense_out),       64'(0));
    chk("rst dense_count",     64'(bus.dense_count),     64'(0));
    chk("rst outlier_idx",     64'(bus.outlier_idx),     64'(0));
    chk("rst outlier_data",    64'(bus.outlier_data),    64'(0));
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post-rst data_in_ready", 64'(bus.data_in_ready), 64'(1));

    // ---------------- table-driven vectors, readies high ----------------
    tv[0] = '{4'b0000, 64'h4400_4200_4000_3C00, 64'h4400_4200_4000_3C00, 3'd0, 0, 8'h00, 64'h0};
    tv[1] = '{4'b1010, 64'hD800_4000_5800_3C00, 64'h0000_4000_0000_3C00, 3'd2, 2, 8'h0D,
              64'h0000_0000_D800_5800};
    tv[2] = '{4'b0001, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_0000, 3'd1, 1, 8'h00,
              64'h0000_0000_0000_1111};
    tv[3] = '{4'b1000, 64'hDDDD_CCCC_BBBB_AAAA, 64'h0000_CCCC_BBBB_AAAA, 3'd1, 1, 8'h03,
              64'h0000_0000_0000_DDDD};
    tv[4] = '{4'b1101, 64'h0004_0003_0002_0001, 64'h0000_0000_0002_0000, 3'd3, 3, 8'h38,
              64'h0000_0004_0003_0001};

    for (int v = 0; v < 5; v++) begin
      send(tv[v].ind, tv[v].data);
      chk($sformatf("v%0d dense_out_valid", v), 64'(bus.dense_out_valid), 64'(1));
      chk($sformatf("v%0d dense_out", v),       64'(bus.dense_out),       tv[v].dense);
      chk($sformatf("v%0d dense_count", v),     64'(bus.dense_count),     64'(tv[v].cnt));
      if (tv[v].n_out == 0) begin
        chk($sformatf("v%0d no outlier", v), 64'(bus.outlier_valid), 64'(0));
        step();
      end else begin
        for (int b = 0; b < tv[v].n_out; b++) begin
          chk($sformatf("v%0d b%0d valid", v, b), 64'(bus.outlier_valid), 64'(1));
          chk($sformatf("v%0d b%0d idx", v, b),   64'(bus.outlier_idx),   64'(tv[v].bidx[2*b +: 2]));
          chk($sformatf("v%0d b%0d data", v, b),  64'(bus.outlier_data),  64'(tv[v].bval[16*b +: 16]));
          chk($sformatf("v%0d b%0d last", v, b),  64'(bus.outlier_last),
              64'(b == tv[v].n_out - 1));
          step();
        end
      end
      chk($sformatf("v%0d ready back", v),     64'(bus.data_in_ready),   64'(1));
      chk($sformatf("v%0d outlier idle", v),   64'(bus.outlier_valid),   64'(0));
      chk($sformatf("v%0d dense idle", v),     64'(bus.dense_out_valid), 64'(0));
    end

    // ---------------- A: all outliers, outlier_ready 1,0,0,1,... ----------------
    begin
      int got;
      got = 0;
      send(4'b1111, 64'h1004_1003_1002_1001);
      chk("A dense_out", 64'(bus.dense_out), 64'h0);
      chk("A dense_count", 64'(bus.dense_count), 64'(4));
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        bus.outlier_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        chk($sformatf("A c%0d valid", cyc), 64'(bus.outlier_valid), 64'(1));
        chk($sformatf("A c%0d idx", cyc),   64'(bus.outlier_idx),   64'(got));
        chk($sformatf("A c%0d data", cyc),  64'(bus.outlier_data),  64'(16'h1001 + 16'(got)));
        chk($sformatf("A c%0d last", cyc),  64'(bus.outlier_last),  64'(got == 3));
        if (bus.outlier_ready) got++;
        step();
      end
      bus.outlier_ready = 1'b1;
      chk("A beat count", 64'(got), 64'(4));
      chk("A outlier idle", 64'(bus.outlier_valid), 64'(0));
      chk("A ready back", 64'(bus.data_in_ready), 64'(1));
    end

    // ---------------- B: dense back-pressure for 10 cycles ----------------
    begin
      int ready_err;
      ready_err = 0;
      bus.dense_out_ready = 1'b0;
      send(4'b0110, 64'h0D00_0C00_0B00_0A00);
      for (int c = 0; c < 10; c++) begin
        if (c == 0) begin
          chk("B b0 idx",  64'(bus.outlier_idx),  64'(1));
          chk("B b0 data", 64'(bus.outlier_data), 64'h0B00);
          chk("B b0 last", 64'(bus.outlier_last), 64'(0));
        end else if (c == 1) begin
          chk("B b1 idx",  64'(bus.outlier_idx),  64'(2));
          chk("B b1 data", 64'(bus.outlier_data), 64'h0C00);
          chk("B b1 last", 64'(bus.outlier_last), 64'(1));
        end
        if (bus.data_in_ready) ready_err++;
        step();
      end
      chk("B ready held low", 64'(ready_err), 64'(0));
      chk("B outliers drained", 64'(bus.outlier_valid), 64'(0));
      chk("B dense still valid", 64'(bus.dense_out_valid), 64'(1));
      chk("B dense stable", 64'(bus.dense_out), 64'h0D00_0000_0000_0A00);
      bus.dense_out_ready = 1'b1;
      step();
      chk("B ready after dense", 64'(bus.data_in_ready), 64'(1));
      chk("B dense done", 64'(bus.dense_out_valid), 64'(0));
    end

    // ---------------- C: reset mid-vector ----------------
    bus.dense_out_ready = 1'b0;
    send(4'b0111, 64'h0000_3003_3002_3001);
    chk("C b0 idx", 64'(bus.outlier_idx), 64'(0));
    step();
    bus.outlier_ready = 1'b0;
    chk("C pre-rst dense_valid", 64'(bus.dense_out_valid), 64'(1));
    chk("C pre-rst outlier_valid", 64'(bus.outlier_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("C rst dense_valid", 64'(bus.dense_out_valid), 64'(0));
    chk("C rst outlier_valid", 64'(bus.outlier_valid), 64'(0));
    chk("C rst ready low", 64'(bus.data_in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("C ready after rst", 64'(bus.data_in_ready), 64'(1));
    bus.dense_out_ready = 1'b1;
    bus.outlier_ready   = 1'b1;
    send(4'b0001, 64'h0000_0000_0000_7777);
    chk("C2 valid", 64'(bus.outlier_valid), 64'(1));
    chk("C2 idx",   64'(bus.outlier_idx),   64'(0));
    chk("C2 data",  64'(bus.outlier_data),  64'h7777);
    chk("C2 last",  64'(bus.outlier_last),  64'(1));
    step();
    chk("C2 single beat", 64'(bus.outlier_valid), 64'(0));
    chk("C2 ready back", 64'(bus.data_in_ready), 64'(1));

    // ---------------- D: back-to-back vectors, random readies ----------------
    begin
      logic [3:0]  di[3];
      logic [63:0] dv[3];
      logic        busy, dd, exp_rdy, exp_dv, exp_ov;
      logic [3:0]  rem, cur_ind;
      logic [63:0] cur;
      int          vi, proto_err, nbeats, low;
      di[0] = 4'b0101; dv[0] = 64'h5004_5003_5002_5001;
      di[1] = 4'b0000; dv[1] = 64'h6004_6003_6002_6001;
      di[2] = 4'b1100; dv[2] = 64'h7004_7003_7002_7001;
      busy = 1'b0; dd = 1'b0; rem = '0; cur_ind = '0; cur = '0;
      vi = 0; proto_err = 0; nbeats = 0;
      for (int cyc = 0; cyc < 300 && !(vi == 3 && !busy); cyc++) begin
        bus.data_in_valid = (vi < 3);
        if (vi < 3) begin
          bus.ind_table = di[vi];
          bus.data_in   = dv[vi];
        end
        bus.dense_out_ready = 1'($urandom_range(0, 1));
        bus.outlier_ready   = 1'($urandom_range(0, 1));
        exp_rdy = !busy;
        exp_dv  = busy && !dd;
        exp_ov  = busy && (rem != 0);
        if (bus.data_in_ready !== exp_rdy || bus.dense_out_valid !== exp_dv ||
            bus.outlier_valid !== exp_ov) proto_err++;
        if (!busy) begin
          if (bus.data_in_valid) begin
            busy = 1'b1; dd = 1'b0;
            rem = di[vi]; cur_ind = di[vi]; cur = dv[vi];
            vi++;
          end
        end else begin
          if (!dd && bus.dense_out_valid && bus.dense_out_ready) begin
            chk($sformatf("D v%0d dense_out", vi - 1), 64'(bus.dense_out), zero_lanes(cur, cur_ind));
            chk($sformatf("D v%0d dense_count", vi - 1), 64'(bus.dense_count), 64'($countones(cur_ind)));
            dd = 1'b1;
          end
          if (rem != 0 && bus.outlier_valid && bus.outlier_ready) begin
            low = 0;
            for (int i = 3; i >= 0; i--) if (rem[i]) low = i;
            chk($sformatf("D v%0d beat idx", vi - 1),  64'(bus.outlier_idx),  64'(low));
            chk($sformatf("D v%0d beat data", vi - 1), 64'(bus.outlier_data), 64'(cur[16*low +: 16]));
            chk($sformatf("D v%0d beat last", vi - 1), 64'(bus.outlier_last), 64'($countones(rem) == 1));
            rem[low] = 1'b0;
            nbeats++;
          end
          if (dd && rem == 0) busy = 1'b0;
        end
        step();
      end
      bus.data_in_valid   = 1'b0;
      bus.dense_out_ready = 1'b1;
      bus.outlier_ready   = 1'b1;
      chk("D vectors accepted", 64'(vi), 64'(3));
      chk("D model drained", 64'(busy), 64'(0));
      chk("D protocol", 64'(proto_err), 64'(0));
      chk("D beat count", 64'(nbeats), 64'(4));
      chk("D ready at end", 64'(bus.data_in_ready), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
